// File: rtl/dot_eater_pkg.sv
// Shared tile geometry, map size and FSM encoding for the dot eater and its neighbours.
// Geometry macros may be predefined by the build; POWER_PELLET_EN is consumed by dot_eater.
`ifndef TILE_SIZE_PX
`define TILE_SIZE_PX 20
`endif
`ifndef TILE_COL_NUM
`define TILE_COL_NUM 32
`endif
`ifndef TILE_ROW_NUM
`define TILE_ROW_NUM 24
`endif
`ifndef WIDTH
`define WIDTH 640
`endif
`ifndef HEIGHT
`define HEIGHT 480
`endif
`ifndef TILE_N
`define TILE_N (`TILE_ROW_NUM*`TILE_COL_NUM)
`endif

package dot_eater_pkg;
    localparam int TILE_SIZE = `TILE_SIZE_PX;
    localparam int TILE_COLS = `TILE_COL_NUM;
    localparam int TILE_ROWS = `TILE_ROW_NUM;
    localparam int N         = `TILE_N;
    localparam int X_W       = $clog2(`WIDTH);
    localparam int Y_W       = $clog2(`HEIGHT);
    localparam int IDX_W     = $clog2(N);
    localparam int CNT_W     = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_PLAY  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;
endpackage

// File: rtl/dot_eater_tile_indexer.sv
// Combinational pixel-to-tile mapping with an in-range flag.
// Shared by the movement, ghost and dot eater stages.
module dot_eater_tile_indexer
    import dot_eater_pkg::*;
(
    input  logic [X_W-1:0]   i_x,
    input  logic [Y_W-1:0]   i_y,
    output logic [IDX_W-1:0] o_tile_idx,
    output logic             o_in_range
);
    logic [31:0] w_col;
    logic [31:0] w_row;
    logic [31:0] w_lin;

    always_comb begin
        w_col = 32'(i_x) / 32'(TILE_SIZE);
        w_row = 32'(i_y) / 32'(TILE_SIZE);
        w_lin = w_row * 32'(TILE_COLS) + w_col;
    end

    // Rows past the bottom of the map produce indices >= N; flag them so callers can drop them.
    assign o_in_range = (w_lin < 32'(N));
    assign o_tile_idx = IDX_W'(w_lin);
endmodule

// File: rtl/dot_eater.sv
// Owns the live dot map: loads it, clears eaten tiles, keeps score and the dot count.
// Define POWER_PELLET_EN to add a second (pellet) map with its own points and pulse.
module dot_eater
    import dot_eater_pkg::*;
#(
    parameter int DOT_POINTS    = 10,
    parameter int PELLET_POINTS = 50,
    parameter int SCORE_W       = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_pos_valid,
    input  logic [X_W-1:0]     i_x,
    input  logic [Y_W-1:0]     i_y,
    input  logic               i_level_load,
    input  logic [N-1:0]       i_init_dots,
`ifdef POWER_PELLET_EN
    input  logic [N-1:0]       i_init_pellets,
    output logic [N-1:0]       o_tilemap_pellets,
    output logic               o_power_pulse,
`endif
    output logic [N-1:0]       o_tilemap_dots,
    output logic [SCORE_W-1:0] o_score,
    output logic [CNT_W-1:0]   o_dots_left,
    output logic               o_eat_pulse,
    output logic               o_level_clear,
    output logic               o_busy
);
    localparam logic [31:0] SCORE_MAX = (32'd1 << SCORE_W) - 32'd1;

    state_t             r_state, w_state_next;
    logic [N-1:0]       r_map;
    logic [CNT_W-1:0]   r_idx, r_count, r_dots_left, w_dots_after;
    logic [SCORE_W-1:0] r_score;
    logic               r_eat_pulse, r_level_clear;
    logic               r_s2_valid, r_s2_in_range;
    logic [IDX_W-1:0]   r_s2_idx, w_tile_idx;
    logic               w_in_range, w_s2_live, w_hit_dot, w_hit_pel, w_eat;
    logic               w_load_dot, w_load_pel;
    logic [1:0]         w_dec, w_load_inc;
    logic [31:0]        w_add, w_sum;

    dot_eater_tile_indexer u_indexer (
        .i_x        (i_x),
        .i_y        (i_y),
        .o_tile_idx (w_tile_idx),
        .o_in_range (w_in_range)
    );

    assign w_load_dot = (r_idx < CNT_W'(N)) ? r_map[r_idx] : 1'b0;
    assign w_s2_live  = (r_state == S_PLAY) && r_s2_valid && r_s2_in_range;
    assign w_hit_dot  = w_s2_live && r_map[r_s2_idx];

`ifdef POWER_PELLET_EN
    logic [N-1:0] r_pel;
    logic         r_power_pulse;
    assign w_load_pel        = (r_idx < CNT_W'(N)) ? r_pel[r_idx] : 1'b0;
    assign w_hit_pel         = w_s2_live && r_pel[r_s2_idx];
    assign o_tilemap_pellets = r_pel;
    assign o_power_pulse     = r_power_pulse;
`else
    assign w_load_pel = 1'b0;
    assign w_hit_pel  = 1'b0;
`endif

    assign w_eat        = w_hit_dot || w_hit_pel;
    assign w_dec        = {1'b0, w_hit_dot} + {1'b0, w_hit_pel};
    assign w_load_inc   = {1'b0, w_load_dot} + {1'b0, w_load_pel};
    assign w_dots_after = r_dots_left - CNT_W'(w_dec);
    assign w_add        = (w_hit_dot ? 32'(DOT_POINTS) : 32'd0) + (w_hit_pel ? 32'(PELLET_POINTS) : 32'd0);
    assign w_sum        = 32'(r_score) + w_add;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // LOAD spends one extra cycle after the walk to publish the count.
    always_comb begin
        w_state_next = r_state;
        if (i_level_load) begin
            w_state_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:  if (r_idx == CNT_W'(N)) w_state_next = (r_count != '0) ? S_PLAY : S_CLEAR;
                S_PLAY:  if (w_eat && (w_dots_after == '0)) w_state_next = S_CLEAR;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_map         <= '0;
            r_idx         <= '0;
            r_count       <= '0;
            r_dots_left   <= '0;
            r_score       <= '0;
            r_eat_pulse   <= 1'b0;
            r_level_clear <= 1'b0;
            r_s2_valid    <= 1'b0;
            r_s2_in_range <= 1'b0;
            r_s2_idx      <= '0;
`ifdef POWER_PELLET_EN
            r_pel         <= '0;
            r_power_pulse <= 1'b0;
`endif
        end else begin
            r_eat_pulse   <= 1'b0;
`ifdef POWER_PELLET_EN
            r_power_pulse <= 1'b0;
`endif
            r_level_clear <= (w_state_next == S_CLEAR);
            r_s2_valid    <= i_pos_valid && (r_state == S_PLAY) && !i_level_load;
            r_s2_idx      <= w_tile_idx;
            r_s2_in_range <= w_in_range;
            // A load overrides any eat resolving in the same cycle.
            if (i_level_load) begin
                r_map   <= i_init_dots;
`ifdef POWER_PELLET_EN
                r_pel   <= i_init_pellets;
`endif
                r_idx   <= '0;
                r_count <= '0;
            end else if (r_state == S_LOAD) begin
                if (r_idx == CNT_W'(N)) begin
                    r_dots_left <= r_count;
                end else begin
                    r_count <= r_count + CNT_W'(w_load_inc);
                    r_idx   <= r_idx + CNT_W'(1);
                end
            end else if (w_eat) begin
                if (w_hit_dot) r_map[r_s2_idx] <= 1'b0;
`ifdef POWER_PELLET_EN
                if (w_hit_pel) r_pel[r_s2_idx] <= 1'b0;
                r_power_pulse <= w_hit_pel;
`endif
                r_score     <= (w_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(w_sum);
                r_dots_left <= w_dots_after;
                r_eat_pulse <= w_hit_dot;
            end
        end
    end

    assign o_tilemap_dots = r_map;
    assign o_score        = r_score;
    assign o_dots_left    = r_dots_left;
    assign o_eat_pulse    = r_eat_pulse;
    assign o_level_clear  = r_level_clear;
    assign o_busy         = (r_state == S_LOAD);
endmodule

// File: tb/tb_dot_eater.sv
// Directed self-checking bench for dot_eater (20-pixel tiles, 32x24 map, 5-bit score).
module tb_dot_eater;
    import dot_eater_pkg::*;

    localparam int SW = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             pos_valid = 1'b0;
    logic             level_load = 1'b0;
    logic [X_W-1:0]   x = '0;
    logic [Y_W-1:0]   y = '0;
    logic [N-1:0]     init_dots = '0;
    logic [N-1:0]     tilemap_dots;
    logic [SW-1:0]    score;
    logic [CNT_W-1:0] dots_left;
    logic             eat_pulse, level_clear, busy;
`ifdef POWER_PELLET_EN
    logic [N-1:0]     init_pellets = '0;
    logic [N-1:0]     tilemap_pellets;
    logic             power_pulse;
`endif

    logic [N-1:0]     exp_map;
    int               errors = 0;
    int               checks = 0;

    always #5 clk = ~clk;

    dot_eater #(.DOT_POINTS(10), .PELLET_POINTS(50), .SCORE_W(SW)) dut (
        .i_clk             (clk),
        .i_reset           (reset_n),
        .i_pos_valid       (pos_valid),
        .i_x               (x),
        .i_y               (y),
        .i_level_load      (level_load),
        .i_init_dots       (init_dots),
`ifdef POWER_PELLET_EN
        .i_init_pellets    (init_pellets),
        .o_tilemap_pellets (tilemap_pellets),
        .o_power_pulse     (power_pulse),
`endif
        .o_tilemap_dots    (tilemap_dots),
        .o_score           (score),
        .o_dots_left       (dots_left),
        .o_eat_pulse       (eat_pulse),
        .o_level_clear     (level_clear),
        .o_busy            (busy)
    );

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic do_load(input logic [N-1:0] m);
        init_dots  = m;
        level_load = 1'b1;
        @(negedge clk);
        level_load = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pos_window(input int px, input int py, input int hold, input int span, output int pulses);
        pulses    = 0;
        x         = X_W'(px);
        y         = Y_W'(py);
        pos_valid = 1'b1;
        for (int i = 0; i < span; i++) begin
            @(negedge clk);
            if (i == hold - 1) pos_valid = 1'b0;
            if (eat_pulse === 1'b1) pulses++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tilemap_dots !== '0) begin errors++; $display("[TB] FAIL reset_map: got %h expected 0", tilemap_dots); end
        checks++; if (score !== 5'd0) begin errors++; $display("[TB] FAIL reset_score: got %0d expected 0", score); end
        checks++; if (dots_left !== '0) begin errors++; $display("[TB] FAIL reset_dots_left: got %0d expected 0", dots_left); end
        checks++; if ({eat_pulse, level_clear, busy} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000", {eat_pulse, level_clear, busy}); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        int n;
        exp_map = '0; exp_map[0] = 1'b1; exp_map[5] = 1'b1; exp_map[34] = 1'b1;
        do_load(exp_map);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL load_busy_start: got %b expected 1", busy); end
        wait_busy(n);
        checks++; if (n != N + 1) begin errors++; $display("[TB] FAIL load_busy_cycles: got %0d expected %0d", n, N + 1); end
        checks++; if (dots_left !== CNT_W'(3)) begin errors++; $display("[TB] FAIL load_dots_left: got %0d expected 3", dots_left); end
        checks++; if (score !== 5'd0) begin errors++; $display("[TB] FAIL load_score: got %0d expected 0", score); end
        checks++; if (level_clear !== 1'b0) begin errors++; $display("[TB] FAIL load_level_clear: got %b expected 0", level_clear); end
        checks++; if (tilemap_dots !== exp_map) begin errors++; $display("[TB] FAIL load_map: got %h expected %h", tilemap_dots, exp_map); end
    endtask

    task automatic test_eat();
        x = X_W'(45); y = Y_W'(25); pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
        checks++; if (tilemap_dots[34] !== 1'b1 || eat_pulse !== 1'b0) begin errors++; $display("[TB] FAIL eat_latency: got bit=%b pulse=%b expected bit=1 pulse=0", tilemap_dots[34], eat_pulse); end
        @(negedge clk);
        exp_map[34] = 1'b0;
        checks++; if (tilemap_dots !== exp_map) begin errors++; $display("[TB] FAIL eat_map: got %h expected %h", tilemap_dots, exp_map); end
        checks++; if (score !== 5'd10) begin errors++; $display("[TB] FAIL eat_score: got %0d expected 10", score); end
        checks++; if (dots_left !== CNT_W'(2)) begin errors++; $display("[TB] FAIL eat_dots_left: got %0d expected 2", dots_left); end
        checks++; if (eat_pulse !== 1'b1) begin errors++; $display("[TB] FAIL eat_pulse_high: got %b expected 1", eat_pulse); end
        @(negedge clk);
        checks++; if (eat_pulse !== 1'b0) begin errors++; $display("[TB] FAIL eat_pulse_width: got %b expected 0", eat_pulse); end
    endtask

    task automatic test_back_to_back();
        int p;
        pos_window(5, 5, 3, 5, p);
        exp_map[0] = 1'b0;
        checks++; if (p != 1) begin errors++; $display("[TB] FAIL repeat_pulses: got %0d expected 1", p); end
        checks++; if (score !== 5'd20) begin errors++; $display("[TB] FAIL repeat_score: got %0d expected 20", score); end
        checks++; if (dots_left !== CNT_W'(1)) begin errors++; $display("[TB] FAIL repeat_dots_left: got %0d expected 1", dots_left); end
        checks++; if (tilemap_dots !== exp_map) begin errors++; $display("[TB] FAIL repeat_map: got %h expected %h", tilemap_dots, exp_map); end
        pos_window(145, 5, 1, 4, p);
        checks++; if (p != 0 || score !== 5'd20 || dots_left !== CNT_W'(1)) begin errors++; $display("[TB] FAIL empty_tile: got pulses=%0d score=%0d left=%0d expected 0/20/1", p, score, dots_left); end
    endtask

    task automatic test_out_of_range();
        int p;
        pos_window(5, 490, 1, 4, p);
        checks++; if (p != 0 || dots_left !== CNT_W'(1)) begin errors++; $display("[TB] FAIL oob_update: got pulses=%0d left=%0d expected 0/1", p, dots_left); end
        checks++; if (tilemap_dots !== exp_map) begin errors++; $display("[TB] FAIL oob_map: got %h expected %h", tilemap_dots, exp_map); end
    endtask

    task automatic test_level_clear_reload();
        int p;
        int n;
        pos_window(105, 5, 1, 2, p);
        checks++; if (score !== 5'd30 || dots_left !== CNT_W'(0)) begin errors++; $display("[TB] FAIL clear_score_left: got %0d/%0d expected 30/0", score, dots_left); end
        checks++; if (level_clear !== 1'b1 || eat_pulse !== 1'b1) begin errors++; $display("[TB] FAIL clear_flag: got clear=%b pulse=%b expected 1/1", level_clear, eat_pulse); end
        pos_window(45, 25, 3, 5, p);
        checks++; if (level_clear !== 1'b1 || tilemap_dots !== '0 || score !== 5'd30) begin errors++; $display("[TB] FAIL clear_hold: got clear=%b score=%0d expected 1/30", level_clear, score); end
        exp_map = '0; exp_map[0] = 1'b1; exp_map[5] = 1'b1; exp_map[34] = 1'b1;
        do_load(exp_map);
        checks++; if (level_clear !== 1'b0 || busy !== 1'b1 || score !== 5'd30) begin errors++; $display("[TB] FAIL reload_start: got clear=%b busy=%b score=%0d expected 0/1/30", level_clear, busy, score); end
        wait_busy(n);
        checks++; if (n != N + 1 || dots_left !== CNT_W'(3)) begin errors++; $display("[TB] FAIL reload_done: got cycles=%0d left=%0d expected %0d/3", n, dots_left, N + 1); end
    endtask

    task automatic test_saturation();
        int p;
        pos_window(45, 25, 1, 2, p);
        checks++; if (score !== 5'd31 || dots_left !== CNT_W'(2)) begin errors++; $display("[TB] FAIL sat_first: got %0d/%0d expected 31/2", score, dots_left); end
        pos_window(5, 5, 1, 2, p);
        checks++; if (score !== 5'd31 || dots_left !== CNT_W'(1) || p != 1) begin errors++; $display("[TB] FAIL sat_hold: got %0d/%0d pulses=%0d expected 31/1/1", score, dots_left, p); end
    endtask

    task automatic test_load_collision();
        logic [N-1:0] m;
        m = '0; m[1] = 1'b1; m[2] = 1'b1; m[3] = 1'b1;
        x = X_W'(105); y = Y_W'(5); pos_valid = 1'b1;
        @(negedge clk);
        pos_valid  = 1'b0;
        init_dots  = m;
        level_load = 1'b1;
        @(negedge clk);
        level_load = 1'b0;
        checks++; if (tilemap_dots !== m) begin errors++; $display("[TB] FAIL collide_map: got %h expected %h", tilemap_dots, m); end
        checks++; if (eat_pulse !== 1'b0 || dots_left !== CNT_W'(1) || busy !== 1'b1) begin errors++; $display("[TB] FAIL collide_eat: got pulse=%b left=%0d busy=%b expected 0/1/1", eat_pulse, dots_left, busy); end
    endtask

    task automatic test_reset_mid_load();
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (tilemap_dots !== '0 || score !== 5'd0 || dots_left !== '0) begin errors++; $display("[TB] FAIL async_reset_state: got score=%0d left=%0d expected 0/0", score, dots_left); end
        checks++; if ({eat_pulse, level_clear, busy} !== 3'b000) begin errors++; $display("[TB] FAIL async_reset_flags: got %b expected 000", {eat_pulse, level_clear, busy}); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load();
        test_eat();
        test_back_to_back();
        test_out_of_range();
        test_level_clear_reload();
        test_saturation();
        test_load_collision();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dot_eater.md
Name: dot_eater

Overview:
- Downstream of the player movement stage: consumes the registered player position and owns the live dot map.
- Clears a dot when the player enters its tile and accumulates the score.
- Counts remaining dots and flags level clear.
- Drives the dot map back to the movement stage and to the renderer.

Parameters:
- DOT_POINTS, 10: score added per dot eaten.
- PELLET_POINTS, 50: score added per power pellet (only with the optional feature).
- SCORE_W, 16: score width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- pos_valid  in  1  one-cycle strobe; x/y carry a new player position.
- x  in  $clog2(`WIDTH)  player x in pixels.
- y  in  $clog2(`HEIGHT)  player y in pixels.
- level_load  in  1  one-cycle pulse; reload the map from init_dots.
- init_dots  in  N  initial dot map, where N = `tile_row_num*`tile_col_num.
- tilemap_dots  out  N  live dot map; bit i set means a dot is present in tile i.
- score  out  SCORE_W  accumulated score.
- dots_left  out  $clog2(N+1)  remaining dots.
- eat_pulse  out  1  one-cycle pulse per dot eaten.
- level_clear  out  1  held high once dots_left reaches 0.
- busy  out  1  high during LOAD.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; tilemap_dots=0, score=0, dots_left=0, eat_pulse=0, level_clear=0, busy=0.
- FSM states: IDLE, LOAD, PLAY, CLEAR.
- level_load has priority in every state. On it:
  - tilemap_dots<=init_dots; load index and counter zeroed; level_clear<=0; pipeline flushed.
  - State goes to LOAD; score is kept (reset alone clears it).
- LOAD:
  - One bit per cycle, index 0..N-1; the counter increments when tilemap_dots[index] is set.
  - After index N-1: dots_left<=count. State goes to PLAY if count>0, otherwise CLEAR.
  - Total N+1 cycles. busy=1 throughout. pos_valid is ignored.
- PLAY eat pipeline:
  - Stage 1, on pos_valid: tile_idx = `tile_col_num*(y/`tile_size) + x/`tile_size; register tile_idx and a valid bit.
  - Stage 2, next cycle: if valid, tile_idx<N and tilemap_dots[tile_idx]=1:
    - clear the bit;
    - score += DOT_POINTS, saturating at 2^SCORE_W-1;
    - dots_left -= 1;
    - eat_pulse=1 for that one cycle.
  - Latency is 2 clocks from the pos_valid edge to the map/score update.
- Boundary conditions:
  - tile_idx>=N: ignored, no update.
  - Back-to-back pos_valid on the same tile: the second lookup reads the already-cleared map, so there is no double count.
  - pos_valid every cycle is accepted at full rate.
  - Last dot eaten (dots_left 1->0): state goes to CLEAR; level_clear=1 from the next cycle and holds until level_load or reset.
- CLEAR: pos_valid is ignored; outputs are stable.
- IDLE: pos_valid is ignored.
- level_load mid-LOAD restarts the walk from index 0. level_load coincident with a stage-2 eat: the load wins and the eat is discarded.

Optional Feature:
- Macro: POWER_PELLET_EN.
- Defined:
  - Adds ports init_pellets (in N), tilemap_pellets (out N) and power_pulse (out 1).
  - Pellets load and clear exactly like dots, and count in dots_left.
  - Eating a pellet adds PELLET_POINTS and pulses power_pulse for one cycle.
  - A tile with both bits set clears both in the same cycle: DOT_POINTS+PELLET_POINTS, dots_left -= 2, both pulses.
- Undefined: the extra ports and logic are absent; behaviour is as above.

Decomposition:
- Shared package/define file:
  - tile constants (`tile_size, `tile_row_num, `tile_col_num, `WIDTH, `HEIGHT);
  - the N macro;
  - FSM state encodings for IDLE/LOAD/PLAY/CLEAR.
- Sub-module tile_indexer: combinational x/y to tile_idx plus an in-range flag. It is reusable by the movement and ghost stages.

Test Plan:
- Reset, then level_load with init_dots bits {0,5,34} set:
  - busy high N+1 cycles, then dots_left=3, state PLAY, score=0.
- Eat a dot (bench defines tile_size=20, tile_col_num=32): pos_valid with x=45, y=25 gives tile 34.
  - Two clocks later, bit 34 is cleared, score=10, dots_left=2, and eat_pulse is high for exactly one cycle.
- Repeat and empty tile:
  - pos_valid on tile 34 for 3 consecutive cycles: a single eat and score=10.
  - pos_valid on empty tile 7: no change.
- Out of range: y beyond the last row gives tile_idx>=N; no update and no pulse.
- Level clear and reload:
  - Eat tiles 0 and 5: score=30, dots_left=0, level_clear=1 and held.
  - Then level_load: level_clear drops, LOAD restarts, score stays 30.
- Saturation, load collision and reset:
  - Score saturation: preload score near max via repeated eats with SCORE_W=5; score sticks at 31.
  - level_load in the same cycle as a stage-2 eat: the map equals init_dots.
  - Reset mid-LOAD: all outputs return to 0 asynchronously.
